// File: rtl/m41mux_pkg.sv
// rtl/m41mux_pkg.sv - select encoding shared by the m41mux block
package m41mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/m41mux_if.sv
// rtl/m41mux_if.sv - data/select bundle and registered status of the 4:1 mux
interface m41mux_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  import m41mux_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  sel_t             sel_q;
  logic             sel_chg;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output a, b, c, d, s1, s0,
    input  y, y_q, sel_q, sel_chg, chg_cnt
  );

  modport slave (
    input  a, b, c, d, s1, s0,
    output y, y_q, sel_q, sel_chg, chg_cnt
  );

endinterface

// File: rtl/m41mux_core.sv
// rtl/m41mux_core.sv - mux, registered copies and select-change tracking
// Change counter present only when M41MUX_CHG_CNT_EN is defined.
module m41mux_core
  import m41mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  m41mux_if.slave    bus
);

  sel_t             sel;
  sel_t             sel_q_r;
  logic [WIDTH-1:0] y_mux;
  logic [WIDTH-1:0] y_q_r;
  logic             sel_chg_r;
  logic             chg;

  assign sel = {bus.s1, bus.s0};
  assign chg = (sel != sel_q_r);

  // Unknown select bits fall to the default arm so y goes all-X in simulation.
  always_comb begin
    y_mux = 'x;
    case (sel)
      SEL_A:   y_mux = bus.a;
      SEL_B:   y_mux = bus.b;
      SEL_C:   y_mux = bus.c;
      SEL_D:   y_mux = bus.d;
      default: y_mux = 'x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_r     <= '0;
      sel_q_r   <= SEL_A;
      sel_chg_r <= 1'b0;
    end else begin
      y_q_r     <= y_mux;
      sel_q_r   <= sel;
      sel_chg_r <= chg;
    end
  end

  assign bus.y       = y_mux;
  assign bus.y_q     = y_q_r;
  assign bus.sel_q   = sel_q_r;
  assign bus.sel_chg = sel_chg_r;

`ifdef M41MUX_CHG_CNT_EN
  logic [CNT_W-1:0] cnt;

  m41mux_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
    .clk (clk),
    .rst (rst),
    .inc (chg),
    .cnt (cnt)
  );

  assign bus.chg_cnt = cnt;
`else
  assign bus.chg_cnt = '0;
`endif

endmodule

// File: rtl/m41mux_sat_cnt.sv
// rtl/m41mux_sat_cnt.sv - up-counter that sticks at all-ones instead of wrapping
module m41mux_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/m41mux.sv
// rtl/m41mux.sv - 4:1 mux top; flat port order kept so legacy (y,a,b,c,d,s1,s0) instances bind
// Change counter present only when M41MUX_CHG_CNT_EN is defined.
module m41mux
  import m41mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s0,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y_q,
  output sel_t             sel_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  m41mux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  assign bus.a  = a;
  assign bus.b  = b;
  assign bus.c  = c;
  assign bus.d  = d;
  assign bus.s1 = s1;
  assign bus.s0 = s0;

  m41mux_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign y       = bus.y;
  assign y_q     = bus.y_q;
  assign sel_q   = bus.sel_q;
  assign sel_chg = bus.sel_chg;
  assign chg_cnt = bus.chg_cnt;

endmodule

// File: tb/tb_m41mux.sv
// tb/tb_m41mux.sv - self-checking bench for m41mux (WIDTH=1/CNT_W=2 and WIDTH=8/CNT_W=8)
`timescale 1ns/1ps
module tb_m41mux;

`ifdef M41MUX_CHG_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  m41mux_if #(.WIDTH(1), .CNT_W(2)) if1 ();
  m41mux_if #(.WIDTH(8), .CNT_W(8)) if8 ();

  m41mux #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .y(if1.y), .a(if1.a), .b(if1.b), .c(if1.c), .d(if1.d), .s1(if1.s1), .s0(if1.s0),
    .clk(clk), .rst(rst), .y_q(if1.y_q), .sel_q(if1.sel_q), .sel_chg(if1.sel_chg),
    .chg_cnt(if1.chg_cnt)
  );

  m41mux #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .y(if8.y), .a(if8.a), .b(if8.b), .c(if8.c), .d(if8.d), .s1(if8.s1), .s0(if8.s0),
    .clk(clk), .rst(rst), .y_q(if8.y_q), .sel_q(if8.sel_q), .sel_chg(if8.sel_chg),
    .chg_cnt(if8.chg_cnt)
  );

  // Reference state: what each registered output should hold after the latest edge.
  logic [1:0] m_prev = 2'b00;
  logic       m_yq1  = 1'b0;
  logic [7:0] m_yq8  = 8'h00;
  logic       m_chg  = 1'b0;
  int         m_cnt1 = 0;
  int         m_cnt8 = 0;

  function automatic logic [7:0] pick(input logic [7:0] va, vb, vc, vd, input logic [1:0] s);
    logic [7:0] v [4];
    v[0] = va; v[1] = vb; v[2] = vc; v[3] = vd;
    return v[s];
  endfunction

  function automatic logic exp_y1();
    logic [7:0] t;
    t = pick({7'b0, if1.a}, {7'b0, if1.b}, {7'b0, if1.c}, {7'b0, if1.d}, {if1.s1, if1.s0});
    return t[0];
  endfunction

  function automatic logic [7:0] exp_y8();
    return pick(if8.a, if8.b, if8.c, if8.d, {if8.s1, if8.s0});
  endfunction

  task automatic set_sel(input logic [1:0] s);
    {if1.s1, if1.s0} = s;
    {if8.s1, if8.s0} = s;
  endtask

  task automatic rand_data();
    {if1.a, if1.b, if1.c, if1.d} = 4'($urandom);
    if8.a = 8'($urandom); if8.b = 8'($urandom);
    if8.c = 8'($urandom); if8.d = 8'($urandom);
  endtask

  // Advance one clock edge, update the reference from the inputs seen at that edge.
  task automatic tick();
    logic [1:0] s;
    @(posedge clk);
    if (rst) begin
      m_prev = 2'b00; m_yq1 = 1'b0; m_yq8 = 8'h00; m_chg = 1'b0; m_cnt1 = 0; m_cnt8 = 0;
    end else begin
      s      = {if8.s1, if8.s0};
      m_yq1  = exp_y1();
      m_yq8  = exp_y8();
      m_chg  = (s != m_prev);
      if (m_chg) begin
        if (m_cnt1 < 3)   m_cnt1++;
        if (m_cnt8 < 255) m_cnt8++;
      end
      m_prev = s;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_sel(2'b11);
    rand_data();
    tick();
    checks++; if (if1.y_q !== 1'b0)      begin errors++; $display("FAIL reset_y_q1 got=%0h exp=0", if1.y_q); end
    checks++; if (if8.y_q !== 8'h00)     begin errors++; $display("FAIL reset_y_q8 got=%0h exp=0", if8.y_q); end
    checks++; if (if8.sel_q !== 2'b00)   begin errors++; $display("FAIL reset_sel_q got=%0d exp=0", if8.sel_q); end
    checks++; if (if1.sel_chg !== 1'b0)  begin errors++; $display("FAIL reset_sel_chg got=%0d exp=0", if1.sel_chg); end
    checks++; if (if8.chg_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt8 got=%0d exp=0", if8.chg_cnt); end
    checks++; if (if1.chg_cnt !== 2'b00) begin errors++; $display("FAIL reset_cnt1 got=%0d exp=0", if1.chg_cnt); end
    checks++; if (if8.y !== if8.d)       begin errors++; $display("FAIL reset_y_live got=%0h exp=%0h", if8.y, if8.d); end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 4; s++) begin
        logic [3:0] pat;
        logic [3:0] expv;
        pat = 4'(p);
        expv = pat;
        {if1.d, if1.c, if1.b, if1.a} = pat;
        set_sel(2'(s));
        #1;
        checks++;
        if (if1.y !== expv[s]) begin
          errors++; $display("FAIL truth_table pat=%0h sel=%0d got=%0b exp=%0b", pat, s, if1.y, expv[s]);
        end
      end
    end
  endtask

  task automatic test_latency();
    set_sel(2'b00);
    if1.a = 1'b1; if1.b = 1'b0; if1.c = 1'b0; if1.d = 1'b0;
    #1;
    checks++; if (if1.y !== 1'b1) begin errors++; $display("FAIL lat_y_same_cycle got=%0b exp=1", if1.y); end
    tick();
    checks++; if (if1.y_q !== 1'b1) begin errors++; $display("FAIL lat_y_q got=%0b exp=1", if1.y_q); end
    checks++; if (if1.y_q !== m_yq1) begin errors++; $display("FAIL lat_y_q_model got=%0b exp=%0b", if1.y_q, m_yq1); end
  endtask

  task automatic test_toggle_stream();
    for (int t = 0; t < 50; t++) begin
      logic [5:0] tv;
      tv = 6'(t);
      set_sel({tv[1], tv[0]});
      if1.a = tv[1]; if1.b = tv[2]; if1.c = tv[3]; if1.d = tv[4];
      if8.a = {8{tv[1]}}; if8.b = {8{tv[2]}} ^ 8'h5a; if8.c = {8{tv[3]}} ^ 8'h0f; if8.d = {8{tv[4]}} ^ 8'hc3;
      #0.5;
      checks++; if (if1.y !== exp_y1()) begin errors++; $display("FAIL stream_y1 t=%0d got=%0b exp=%0b", t, if1.y, exp_y1()); end
      checks++; if (if8.y !== exp_y8()) begin errors++; $display("FAIL stream_y8 t=%0d got=%0h exp=%0h", t, if8.y, exp_y8()); end
      #0.5;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sel_change();
    set_sel(2'b00);
    tick();
    set_sel(2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if8.sel_chg !== (i == 0)) begin errors++; $display("FAIL sel_chg_pulse cyc=%0d got=%0b exp=%0b", i, if8.sel_chg, (i == 0)); end
      checks++;
      if (if8.sel_q !== 2'b10) begin errors++; $display("FAIL sel_chg_sel_q cyc=%0d got=%0d exp=2", i, if8.sel_q); end
    end
    checks++;
    if (if8.chg_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL sel_chg_cnt got=%0d exp=%0d", if8.chg_cnt, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_saturate();
    logic [1:0] seq [5];
    seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b00; seq[4] = 2'b01;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_sel(seq[i]);
      tick();
      checks++; if (if1.sel_chg !== 1'b1) begin errors++; $display("FAIL sat_pulse i=%0d got=%0b exp=1", i, if1.sel_chg); end
      checks++; if (if1.chg_cnt !== 2'(CNT_EN ? m_cnt1 : 0)) begin errors++; $display("FAIL sat_cnt1 i=%0d got=%0d exp=%0d", i, if1.chg_cnt, CNT_EN ? m_cnt1 : 0); end
    end
    checks++; if (if1.chg_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin errors++; $display("FAIL sat_final1 got=%0d exp=%0d", if1.chg_cnt, CNT_EN ? 3 : 0); end
    checks++; if (if8.chg_cnt !== (CNT_EN ? 8'd5 : 8'd0)) begin errors++; $display("FAIL sat_final8 got=%0d exp=%0d", if8.chg_cnt, CNT_EN ? 5 : 0); end
    set_sel(2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({if1.y_q, if1.sel_q, if1.sel_chg, if1.chg_cnt} !== 6'b0) begin
      errors++; $display("FAIL sat_reset got=%0h exp=0", {if1.y_q, if1.sel_q, if1.sel_chg, if1.chg_cnt});
    end
  endtask

  task automatic test_reset_mid();
    set_sel(2'b10);
    rand_data();
    tick();
    rst = 1'b1;
    set_sel(2'b01);
    #2;
    checks++; if (if8.sel_q !== 2'b10) begin errors++; $display("FAIL mid_rst_hold got=%0d exp=2", if8.sel_q); end
    checks++; if (if8.y !== if8.b)     begin errors++; $display("FAIL mid_rst_y_live got=%0h exp=%0h", if8.y, if8.b); end
    tick();
    checks++; if (if8.y_q !== 8'h00 || if8.sel_q !== 2'b00 || if8.sel_chg !== 1'b0 || if8.chg_cnt !== 8'h00) begin
      errors++; $display("FAIL mid_rst_clear y_q=%0h sel_q=%0d chg=%0b cnt=%0d exp=all 0", if8.y_q, if8.sel_q, if8.sel_chg, if8.chg_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      rand_data();
      set_sel(2'($urandom));
      rst = ($urandom_range(0, 19) == 0);
      #1;
      checks++; if (if8.y !== exp_y8()) begin errors++; $display("FAIL b2b_y8 i=%0d got=%0h exp=%0h", i, if8.y, exp_y8()); end
      tick();
      checks++; if (if1.y_q !== m_yq1)     begin errors++; $display("FAIL b2b_y_q1 i=%0d got=%0b exp=%0b", i, if1.y_q, m_yq1); end
      checks++; if (if8.y_q !== m_yq8)     begin errors++; $display("FAIL b2b_y_q8 i=%0d got=%0h exp=%0h", i, if8.y_q, m_yq8); end
      checks++; if (if8.sel_q !== m_prev)  begin errors++; $display("FAIL b2b_sel_q i=%0d got=%0d exp=%0d", i, if8.sel_q, m_prev); end
      checks++; if (if8.sel_chg !== m_chg) begin errors++; $display("FAIL b2b_sel_chg i=%0d got=%0b exp=%0b", i, if8.sel_chg, m_chg); end
      checks++; if (if1.chg_cnt !== 2'(CNT_EN ? m_cnt1 : 0)) begin errors++; $display("FAIL b2b_cnt1 i=%0d got=%0d exp=%0d", i, if1.chg_cnt, CNT_EN ? m_cnt1 : 0); end
      checks++; if (if8.chg_cnt !== 8'(CNT_EN ? m_cnt8 : 0)) begin errors++; $display("FAIL b2b_cnt8 i=%0d got=%0d exp=%0d", i, if8.chg_cnt, CNT_EN ? m_cnt8 : 0); end
    end
    rst = 1'b0;
  endtask

  initial begin
    set_sel(2'b00);
    rand_data();
    #2;
    test_reset();
    test_truth_table();
    test_latency();
    test_toggle_stream();
    test_sel_change();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
